// File: rtl/elc3_soc_sysid_checker_pkg.sv
// Shared types and constants for the system-ID build checker.
package elc3_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1493141956;

    localparam int WAIT_CNT_W  = 16;
    localparam int RETRY_CNT_W = 5;

endpackage

// File: rtl/elc3_soc_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave (slave).
// Handshake: a read transfer completes on the rising edge where read=1 and waitrequest=0;
// while waitrequest=1 the master holds read and address stable and readdata is ignored.
interface elc3_soc_sysid_checker_if;
    logic        address;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, output read, input readdata, input waitrequest);
    modport slave  (input address, input read, output readdata, output waitrequest);
endinterface

// File: rtl/elc3_soc_sysid_checker_wait_timer.sv
// Stall counter for one read attempt; tc fires on the LIMIT-th consecutive stalled cycle.
module elc3_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    import elc3_sysid_pkg::*;

    localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(LIMIT - 1);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    assign tc = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/elc3_soc_sysid_checker.sv
// Reads the sysid ID and timestamp words, compares them to the expected build and
// reports pass/mismatch/timeout so boot logic can hold the CPU on a wrong image.
module elc3_soc_sysid_checker
    import elc3_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TS,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter bit          AUTO_START         = 1'b1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    elc3_soc_sysid_checker_if.master        avm,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            id_mismatch,
    output logic                            ts_mismatch,
    output logic                            timeout,
    output logic [31:0]                     captured_id,
    output logic [31:0]                     captured_ts,
    output logic [2:0]                      dbg_state
);

    state_e                 state_q, state_d;
    logic                   gap_q, gap_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;
    logic                   auto_q, auto_d;
    logic                   id_mm_q, id_mm_d;
    logic                   ts_mm_q, ts_mm_d;
    logic                   timeout_q, timeout_d;
    logic                   pass_q, pass_d;
    logic [31:0]            cap_id_q, cap_id_d;
    logic [31:0]            cap_ts_q, cap_ts_d;

    logic in_read, read_o, stall, xfer, launch, tc;

    assign in_read = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    assign read_o  = in_read && !gap_q;
    assign stall   = read_o && avm.waitrequest;
    assign xfer    = read_o && !avm.waitrequest;
    assign launch  = (start || auto_q) && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Counter is held at zero whenever the bus is not stalled, so each attempt starts fresh.
    elc3_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clk   (clock),
        .rst_n (reset_n),
        .load  (!stall || tc),
        .en    (stall),
        .tc    (tc)
    );

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        retry_d   = retry_q;
        auto_d    = auto_q;
        id_mm_d   = id_mm_q;
        ts_mm_d   = ts_mm_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d   = ST_RD_ID;
                    gap_d     = 1'b0;
                    retry_d   = '0;
                    auto_d    = 1'b0;
                    id_mm_d   = 1'b0;
                    ts_mm_d   = 1'b0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    if (retry_q > RETRY_CNT_W'(MAX_RETRIES)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if (xfer) begin
                    retry_d = '0;
                    if (state_q == ST_RD_ID) begin
                        cap_id_d = avm.readdata;
                        state_d  = ST_RD_TS;
                    end else begin
                        cap_ts_d = avm.readdata;
                        state_d  = ST_COMPARE;
                    end
                end else if (tc) begin
                    gap_d   = 1'b1;
                    retry_d = retry_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                id_mm_d = (cap_id_q != EXPECTED_ID);
                ts_mm_d = CHECK_TIMESTAMP && (cap_ts_q != EXPECTED_TIMESTAMP);
                pass_d  = !id_mm_d && !ts_mm_d && !timeout_q;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gap_q     <= 1'b0;
            retry_q   <= '0;
            auto_q    <= AUTO_START;
            id_mm_q   <= 1'b0;
            ts_mm_q   <= 1'b0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            retry_q   <= retry_d;
            auto_q    <= auto_d;
            id_mm_q   <= id_mm_d;
            ts_mm_q   <= ts_mm_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    assign avm.read    = read_o;
    assign avm.address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = in_read || (state_q == ST_COMPARE);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q && done;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_elc3_soc_sysid_checker.sv
// Directed bench: one checker with timestamp checking and auto-start, one without either.
module tb_elc3_soc_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'd1493141956;

    logic clk;
    logic reset_n;
    logic start;
    logic start2;

    logic [31:0] id_val;
    logic [31:0] ts_val;
    int          ws;
    logic        stuck;
    int          stall_cnt;

    int total;
    int fails;

    logic        busy, done, pass, id_mm, ts_mm, tmo;
    logic [31:0] cap_id, cap_ts;
    logic [2:0]  dbg;

    logic        busy2, done2, pass2, id_mm2, ts_mm2, tmo2;
    logic [31:0] cap_id2, cap_ts2;
    logic [2:0]  dbg2;

    elc3_soc_sysid_checker_if bus ();
    elc3_soc_sysid_checker_if bus2 ();

    // Slave model: a fixed number of wait-states per read, or stuck stalled.
    assign bus.readdata    = bus.address ? ts_val : id_val;
    assign bus.waitrequest = stuck || (bus.read && (stall_cnt < ws));
    assign bus2.readdata    = bus2.address ? 32'd0 : 32'd0;
    assign bus2.waitrequest = 1'b0;

    always @(posedge clk) begin
        if (!bus.read || !bus.waitrequest) begin
            stall_cnt <= 0;
        end else begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    elc3_soc_sysid_checker #(
        .CHECK_TIMESTAMP (1'b1),
        .AUTO_START      (1'b1),
        .TIMEOUT_CYCLES  (8),
        .MAX_RETRIES     (2)
    ) u_dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_mismatch (id_mm),
        .ts_mismatch (ts_mm),
        .timeout     (tmo),
        .captured_id (cap_id),
        .captured_ts (cap_ts),
        .dbg_state   (dbg)
    );

    elc3_soc_sysid_checker #(
        .CHECK_TIMESTAMP (1'b0),
        .AUTO_START      (1'b0)
    ) u_dut2 (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start2),
        .avm         (bus2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .id_mismatch (id_mm2),
        .ts_mismatch (ts_mm2),
        .timeout     (tmo2),
        .captured_id (cap_id2),
        .captured_ts (cap_ts2),
        .dbg_state   (dbg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        total   = 0;
        fails   = 0;
        reset_n = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        id_val  = 32'd0;
        ts_val  = GOOD_TS;
        ws      = 0;
        stuck   = 1'b0;

        // Reset values
        #3 reset_n = 1'b0;
        cyc(3);
        check("rst_read", {31'd0, bus.read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_cap_id", cap_id, 32'd0);
        check("rst_cap_ts", cap_ts, 32'd0);
        reset_n = 1'b1;

        // Auto-start launches on the first edge after release; the other instance stays idle
        cyc(1);
        check("auto_read", {31'd0, bus.read}, 32'd1);
        check("auto_addr", {31'd0, bus.address}, 32'd0);
        check("noauto_busy", {31'd0, busy2}, 32'd0);
        wait_done("auto_done", 20);
        check("auto_pass", {31'd0, pass}, 32'd1);
        check("auto_cap_ts", cap_ts, GOOD_TS);

        // Timestamp excluded from pass
        pulse_start2();
        check("nots_read", {31'd0, bus2.read}, 32'd1);
        cyc(3);
        check("nots_done", {31'd0, done2}, 32'd1);
        check("nots_pass", {31'd0, pass2}, 32'd1);
        check("nots_ts_mm", {31'd0, ts_mm2}, 32'd0);
        check("nots_cap_ts", cap_ts2, 32'd0);

        // Zero-wait cycle-exact sequence
        pulse_start();
        check("zw_n1_read", {31'd0, bus.read}, 32'd1);
        check("zw_n1_addr", {31'd0, bus.address}, 32'd0);
        check("zw_n1_pass", {31'd0, pass}, 32'd0);
        cyc(1);
        check("zw_n2_read", {31'd0, bus.read}, 32'd1);
        check("zw_n2_addr", {31'd0, bus.address}, 32'd1);
        cyc(1);
        check("zw_n3_read", {31'd0, bus.read}, 32'd0);
        check("zw_n3_busy", {31'd0, busy}, 32'd1);
        check("zw_n3_done", {31'd0, done}, 32'd0);
        cyc(1);
        check("zw_n4_done", {31'd0, done}, 32'd1);
        check("zw_n4_pass", {31'd0, pass}, 32'd1);
        check("zw_n4_busy", {31'd0, busy}, 32'd0);

        // ID mismatch
        id_val = 32'h1;
        pulse_start();
        cyc(3);
        check("idmm_done", {31'd0, done}, 32'd1);
        check("idmm_flag", {31'd0, id_mm}, 32'd1);
        check("idmm_pass", {31'd0, pass}, 32'd0);
        check("idmm_cap", cap_id, 32'h1);
        check("idmm_ts_mm", {31'd0, ts_mm}, 32'd0);
        id_val = 32'd0;

        // Timestamp mismatch with checking enabled
        ts_val = 32'd0;
        pulse_start();
        cyc(3);
        check("tsmm_flag", {31'd0, ts_mm}, 32'd1);
        check("tsmm_pass", {31'd0, pass}, 32'd0);
        check("tsmm_cap", cap_ts, 32'd0);
        ts_val = GOOD_TS;

        // Three wait-states per read; a start pulse mid-stall must be ignored
        ws = 3;
        pulse_start();
        check("ws_n1_read", {31'd0, bus.read}, 32'd1);
        cyc(2);
        check("ws_n3_read", {31'd0, bus.read}, 32'd1);
        check("ws_n3_addr", {31'd0, bus.address}, 32'd0);
        pulse_start();
        check("ws_n4_addr", {31'd0, bus.address}, 32'd0);
        cyc(1);
        check("ws_n5_addr", {31'd0, bus.address}, 32'd1);
        cyc(3);
        check("ws_n8_read", {31'd0, bus.read}, 32'd1);
        check("ws_n8_addr", {31'd0, bus.address}, 32'd1);
        cyc(1);
        check("ws_n9_done", {31'd0, done}, 32'd0);
        cyc(1);
        check("ws_n10_done", {31'd0, done}, 32'd1);
        check("ws_n10_pass", {31'd0, pass}, 32'd1);
        ws = 0;

        // Stuck waitrequest: 3 attempts of 8 cycles, each followed by one idle cycle
        stuck = 1'b1;
        pulse_start();
        check("to_n1_read", {31'd0, bus.read}, 32'd1);
        cyc(7);
        check("to_n8_read", {31'd0, bus.read}, 32'd1);
        cyc(1);
        check("to_n9_read", {31'd0, bus.read}, 32'd0);
        check("to_n9_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        check("to_n10_read", {31'd0, bus.read}, 32'd1);
        check("to_n10_addr", {31'd0, bus.address}, 32'd0);
        cyc(8);
        check("to_n18_read", {31'd0, bus.read}, 32'd0);
        cyc(1);
        check("to_n19_read", {31'd0, bus.read}, 32'd1);
        cyc(8);
        check("to_n27_read", {31'd0, bus.read}, 32'd0);
        check("to_n27_done", {31'd0, done}, 32'd0);
        cyc(1);
        check("to_n28_done", {31'd0, done}, 32'd1);
        check("to_flag", {31'd0, tmo}, 32'd1);
        check("to_pass", {31'd0, pass}, 32'd0);
        check("to_id_mm", {31'd0, id_mm}, 32'd0);
        stuck = 1'b0;

        // Reset during the timestamp read stall, then auto-start reruns
        ws = 5;
        pulse_start();
        cyc(6);
        check("rs_addr_ts", {31'd0, bus.address}, 32'd1);
        check("rs_read_ts", {31'd0, bus.read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rs_read_drop", {31'd0, bus.read}, 32'd0);
        check("rs_busy_drop", {31'd0, busy}, 32'd0);
        check("rs_cap_ts", cap_ts, 32'd0);
        check("rs_cap_id", cap_id, 32'd0);
        ws = 0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        check("rs_auto_busy", {31'd0, busy}, 32'd1);
        wait_done("rs_done", 20);
        check("rs_pass", {31'd0, pass}, 32'd1);
        check("rs_cap_ts_after", cap_ts, GOOD_TS);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/elc3_soc_sysid_checker.md
# elc3_soc_sysid_checker

Avalon-MM read master that interrogates the system-ID peripheral on the `control_slave` interface and verifies the build. After reset (optionally) or on a `start` pulse, it reads the ID word (address 0) and timestamp word (address 1), compares both against parameterised expected values, and reports pass/fail/timeout status. It sits beside the boot logic in the SoC and gates `pass` into the CPU release path, so a mismatched FPGA image is caught before software runs.

## Interface
- `EXPECTED_ID`, 32'd0, value required at address 0
- `EXPECTED_TIMESTAMP`, 32'd1493141956, value required at address 1
- `CHECK_TIMESTAMP`, 1, 0 = timestamp captured but excluded from `pass`
- `AUTO_START`, 1, 1 = check launches once after reset release
- `TIMEOUT_CYCLES`, 255, max wait-states per read before abort (1..65535)
- `MAX_RETRIES`, 3, reissues of a timed-out read before failing (0..15)
- `clock`  in  1  system clock; all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle launch request
- `address`  out  1  word address to sysid slave
- `read`  out  1  Avalon read strobe
- `readdata`  in  32  slave read data
- `waitrequest`  in  1  slave stall
- `busy`  out  1  check in progress
- `done`  out  1  check finished, held until next launch
- `pass`  out  1  all enabled comparisons matched
- `id_mismatch`  out  1  ID word differed
- `ts_mismatch`  out  1  timestamp differed (only when CHECK_TIMESTAMP=1)
- `timeout`  out  1  retries exhausted on some read
- `captured_id`  out  32  last ID word read
- `captured_ts`  out  32  last timestamp word read

## Operation
- States: IDLE, RD_ID, RD_TS, COMPARE, DONE.
- IDLE: on `start` (or first cycle after reset when AUTO_START=1) clear status flags, captures unchanged, go RD_ID.
- RD_ID/RD_TS: drive `read`=1, `address`=0/1; hold both stable while `waitrequest`=1. Transfer completes on the edge where `read`&&!`waitrequest`; `readdata` captured there; advance RD_ID→RD_TS→COMPARE.
- Timeout: wait counter resets on entering a read state, increments each stalled cycle; when it reaches TIMEOUT_CYCLES, drop `read` for one cycle, increment retry counter, reissue same address. Retry counter exceeding MAX_RETRIES → set `timeout`, go DONE (remaining reads skipped, comparisons not performed).
- COMPARE: one cycle; set mismatch flags; `pass` = no mismatch and no timeout.
- DONE: `done`=1; `start` relaunches (→RD_ID via flag clear). `start` while `busy` ignored.
- `busy` = state is RD_ID, RD_TS or COMPARE.

## Timing
- Reset (asynchronous): state IDLE; `read`,`address`,`busy`,`done`,`pass`, all flags, captures = 0. Reset mid-read drops `read` immediately; no completion recorded.
- With `waitrequest` tied 0: `start` sampled at edge N; `read` high cycles N+1 (addr 0) and N+2 (addr 1); COMPARE cycle N+3; `done`/`pass` valid from cycle N+4.
- Each wait-state adds exactly one cycle. Timeout abort costs TIMEOUT_CYCLES + 1 idle cycle per attempt.
- `pass` valid only while `done`=1; it is 0 otherwise.
- `start` coincident with AUTO_START launch: single check only.

## Structure
- Package `elc3_sysid_pkg`: state enum, `SYSID_ADDR_ID`=1'b0, `SYSID_ADDR_TS`=1'b1, default expected constants.
- Sub-module `elc3_wait_timer`: loadable stall counter with terminal-count flag, reused per read.

## Test plan
- Zero-wait slave returning 0 / 1493141956, `start` at cycle 10 → `done`=1,`pass`=1 at cycle 14, captures match.
- Slave returns ID 32'h1 → `id_mismatch`=1, `pass`=0, `captured_id`=1.
- Timestamp 32'h0 with CHECK_TIMESTAMP=0 → `pass`=1, `ts_mismatch`=0, `captured_ts`=0.
- `waitrequest` high 3 cycles per read → `done` at start+10, `address`/`read` stable throughout stalls.
- `waitrequest` stuck high, TIMEOUT_CYCLES=8, MAX_RETRIES=2 → three attempts with one-cycle `read` gaps, then `timeout`=1, `pass`=0.
- `reset_n` low during RD_TS stall → `read`=0 same cycle; after release, AUTO_START reruns check to `pass`=1.
